// File: rtl/aes_blk_loader.sv
// aes_blk_loader: pops full 128-bit blocks from the input FIFO and routes them to the AES core.
// Optional accepted-block counter is enabled by defining AES_BLK_LOADER_BLKCNT_EN.
module aes_blk_loader #(
    parameter int BLK_W = 128,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    input  logic [BLK_W-1:0] fifo_data,
    output logic             fifo_read_en,
    input  logic             key_req,
    input  logic             flush,
    output logic [BLK_W-1:0] blk_data,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic [BLK_W-1:0] key_data,
    output logic             key_valid,
    output logic             busy,
    output logic [CNT_W-1:0] blk_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] POP     = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] PRESENT = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             key_pending_q, key_pending_d;
    logic             key_valid_q, key_valid_d;
    logic [BLK_W-1:0] blk_data_q, blk_data_d;
    logic [BLK_W-1:0] key_data_q, key_data_d;
    logic             pop_ok;
    logic             unused_empty;

    // Writes win over reads in the FIFO: still full means the pop was dropped.
    // A non-empty, non-full FIFO means a write landed alongside a good pop.
    assign pop_ok       = !fifo_full;
    assign unused_empty = fifo_empty;

    always_comb begin
        state_d       = state_q;
        key_pending_d = key_pending_q | key_req;
        key_valid_d   = 1'b0;
        blk_data_d    = blk_data_q;
        key_data_d    = key_data_q;
        case (state_q)
            IDLE: begin
                if (fifo_full) state_d = POP;
            end
            POP: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!pop_ok) begin
                    state_d = POP;
                end else if (key_pending_q) begin
                    key_data_d    = fifo_data;
                    key_valid_d   = 1'b1;
                    key_pending_d = key_req;
                    state_d       = IDLE;
                end else begin
                    blk_data_d = fifo_data;
                    state_d    = PRESENT;
                end
            end
            PRESENT: begin
                if (blk_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d       = IDLE;
            key_pending_d = 1'b0;
            key_valid_d   = 1'b0;
            blk_data_d    = blk_data_q;
            key_data_d    = key_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            key_pending_q <= 1'b0;
            key_valid_q   <= 1'b0;
            blk_data_q    <= '0;
            key_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            key_pending_q <= key_pending_d;
            key_valid_q   <= key_valid_d;
            blk_data_q    <= blk_data_d;
            key_data_q    <= key_data_d;
        end
    end

    assign fifo_read_en = (state_q == POP);
    assign blk_valid    = (state_q == PRESENT);
    assign busy         = (state_q != IDLE);
    assign blk_data     = blk_data_q;
    assign key_data     = key_data_q;
    assign key_valid    = key_valid_q;

`ifdef AES_BLK_LOADER_BLKCNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             hshake;

    assign hshake = (state_q == PRESENT) && blk_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt_q <= '0;
        end else if (hshake) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign blk_count = cnt_q;
`else
    assign blk_count = '0;
`endif

endmodule

// File: doc/aes_blk_loader.md
Name: aes_blk_loader

Overview:
- Sits directly downstream of the 128-bit APB input FIFO and upstream of the AES-128 core.
- Pops one full 128-bit block from the FIFO once all four 32-bit words are loaded.
- Routes the block either to the core's data port (valid/ready handshake) or to its key port (single-cycle strobe), depending on a pending key-load request.
- Detects and retries pops that the FIFO silently drops.

Parameters:
- BLK_W, 128, width of FIFO block and core data/key buses.
- CNT_W, 16, width of the block counter (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- fifo_full  in  1  FIFO holds 4 words
- fifo_empty  in  1  FIFO holds 0 words
- fifo_data  in  BLK_W  FIFO registered block output, valid the cycle after a successful pop
- fifo_read_en  out  1  pop request to FIFO
- key_req  in  1  single-cycle pulse: next popped block is a key
- flush  in  1  synchronous abort to IDLE
- blk_data  out  BLK_W  block to AES core
- blk_valid  out  1  blk_data valid
- blk_ready  in  1  core accepts blk_data
- key_data  out  BLK_W  key to AES core
- key_valid  out  1  one-cycle key strobe
- busy  out  1  high in any state other than IDLE
- blk_count  out  CNT_W  accepted-block counter (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, fifo_read_en=0, blk_valid=0, key_valid=0, busy=0, blk_data=0, key_data=0, key_pending=0, blk_count=0. Reset overrides flush and every other input, mid-operation included.
- FSM states: IDLE, POP, CAPTURE, PRESENT. fifo_read_en is a Moore output: 1 only in POP.
- IDLE: if fifo_full=1, go to POP next cycle; otherwise stay.
- POP: fifo_read_en=1 for exactly this cycle. Always go to CAPTURE.
- CAPTURE: validates the pop. The FIFO gives writes priority over reads, so a pop coinciding with a write is lost.
  - If fifo_full=1 (pop dropped): go back to POP (retry). No data is captured.
  - Otherwise, if key_pending=1: key_data<=fifo_data, key_valid=1 in the following cycle only, key_pending<=0, go to IDLE.
  - Otherwise: blk_data<=fifo_data, go to PRESENT.
- PRESENT: blk_valid=1. blk_data is held stable while blk_valid=1 and blk_ready=0. On blk_valid&blk_ready, go to IDLE; blk_valid=0 from the next cycle.
- Latency: fifo_full first seen high in IDLE (cycle 0) → fifo_read_en cycle 1 → CAPTURE cycle 2 → blk_valid or key_valid cycle 3. Minimum 4 cycles per block including the IDLE re-check.
- key_req: sampled in every state. Sets key_pending, which persists until a key capture. It affects only the next CAPTURE, not one already in progress when key_req arrives in the same cycle. key_req while key_pending=1 has no extra effect.
- flush: from any state, next state is IDLE with blk_valid=0, key_valid=0, key_pending=0. blk_data and key_data keep their values. If flush coincides with POP, the FIFO pop may already have taken effect; that block is discarded.
- fifo_empty is used only to qualify CAPTURE: fifo_full=0 and fifo_empty=1 marks a successful pop. fifo_full=0 and fifo_empty=0 (a concurrent write landed) is also treated as a successful pop.
- No combinational path from any input to any output. All outputs are registered or decoded from state.

Optional Feature:
- Macro AES_BLK_LOADER_BLKCNT_EN.
- Defined: blk_count increments by 1 on each blk_valid&blk_ready handshake. Wraps from 2^CNT_W-1 to 0. Cleared by rst and flush. Key captures do not count.
- Undefined: blk_count port still exists, tied to constant 0, with no counter logic.

Test Plan:
- Reset then fifo_full=1, fifo_data=128'h00112233_44556677_8899AABB_CCDDEEFF, blk_ready=1 → fifo_read_en high exactly cycle 1; blk_valid=1 with that data in cycle 3; back to IDLE in cycle 4.
- Same block with blk_ready=0 for 5 cycles then 1 → blk_valid and blk_data stable all 5 cycles; a single handshake; blk_count=1 (macro on), 0 (macro off).
- key_req pulse in IDLE, then a full FIFO with data=128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C → key_valid one cycle with that key_data; blk_valid never asserts. The next full block goes to blk_data.
- Hold fifo_full=1 through CAPTURE (simulated dropped pop) → fifo_read_en re-asserts in the following cycle. Capture occurs only after fifo_full falls.
- Assert flush in PRESENT with blk_ready=0 → blk_valid=0 next cycle, busy=0, blk_count=0. Assert rst in POP → all outputs at reset values next cycle.
- Macro on, CNT_W=2: 5 handshakes → blk_count sequence 1,2,3,0,1.
